// File: rtl/elapsed_counter_pkg.sv
// ----------------------------------------------------------------------------
// elapsed_counter_pkg
// Shared types and constants for the elapsed-time counter.
//   elap_state_t  : 2-bit controller state encoding (idle / waiting on timer)
//   *_MAX         : terminal value of each BCD digit before it wraps to 0
// ----------------------------------------------------------------------------
package elapsed_counter_pkg;

  typedef enum logic [1:0] {
    ELAP_IDLE_S = 2'd0,
    ELAP_WAIT_S = 2'd1
  } elap_state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/elapsed_counter_if.sv
// ----------------------------------------------------------------------------
// elapsed_counter_if
// Control and display bundle of the elapsed-time counter.
//   CLR, RUN, LAP, TMR_PULSE         : controls and timer expiry (master -> slave)
//   START_TMR, STOP_TMR              : timer re-arm / abort pulses (slave -> master)
//   SEC_ONES..MIN_TENS, HOURS        : displayed BCD digits (slave -> master)
//   LAP_ACTIVE, ROLLOVER             : display-freeze flag, wrap pulse
// Macro ELAPSED_HOURS_EN adds the HOURS digit.
// ----------------------------------------------------------------------------
interface elapsed_counter_if;

  logic       CLR;
  logic       RUN;
  logic       LAP;
  logic       TMR_PULSE;
  logic       START_TMR;
  logic       STOP_TMR;
  logic [3:0] SEC_ONES;
  logic [3:0] SEC_TENS;
  logic [3:0] MIN_ONES;
  logic [3:0] MIN_TENS;
`ifdef ELAPSED_HOURS_EN
  logic [3:0] HOURS;
`endif
  logic       LAP_ACTIVE;
  logic       ROLLOVER;

`ifdef ELAPSED_HOURS_EN
  modport master (
    output CLR, RUN, LAP, TMR_PULSE,
    input  START_TMR, STOP_TMR, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS,
           HOURS, LAP_ACTIVE, ROLLOVER
  );
  modport slave (
    input  CLR, RUN, LAP, TMR_PULSE,
    output START_TMR, STOP_TMR, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS,
           HOURS, LAP_ACTIVE, ROLLOVER
  );
`else
  modport master (
    output CLR, RUN, LAP, TMR_PULSE,
    input  START_TMR, STOP_TMR, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS,
           LAP_ACTIVE, ROLLOVER
  );
  modport slave (
    input  CLR, RUN, LAP, TMR_PULSE,
    output START_TMR, STOP_TMR, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS,
           LAP_ACTIVE, ROLLOVER
  );
`endif

endinterface

// File: rtl/elapsed_counter_bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
// One decade of the live count; wraps from MAX_VAL back to 0.
//   CLK, RST_N : clock, asynchronous active-low reset
//   CLR        : synchronous clear (wins over INC)
//   INC        : advance by one this cycle
//   DIGIT      : registered digit value
//   CARRY      : combinational, INC while DIGIT == MAX_VAL
// ----------------------------------------------------------------------------
module bcd_digit #(
  parameter logic [3:0] MAX_VAL = 4'd9
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CLR,
  input  logic       INC,
  output logic [3:0] DIGIT,
  output logic       CARRY
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  assign CARRY = INC && (digit_q == MAX_VAL);
  assign DIGIT = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (CLR) begin
      digit_d = 4'd0;
    end else if (INC) begin
      digit_d = (digit_q == MAX_VAL) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/elapsed_counter.sv
// ----------------------------------------------------------------------------
// elapsed_counter
// Counts expiry pulses of a one-shot timer into a BCD mm:ss (or h:mm:ss)
// elapsed time and re-arms the timer after each expiry so it ticks
// periodically. Supports run/pause, clear and a lap (display freeze).
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : elapsed_counter_if.slave (controls, timer handshake, display)
// Parameter TICKS_PER_SEC (1..255): timer pulses per one-second increment.
// Macro ELAPSED_HOURS_EN adds an HOURS digit; rollover moves to 9:59:59.
// ----------------------------------------------------------------------------
module elapsed_counter
  import elapsed_counter_pkg::*;
#(
  parameter logic [7:0] TICKS_PER_SEC = 8'd1
) (
  input  logic              CLK,
  input  logic              RST_N,
  elapsed_counter_if.slave  bus
);

  localparam logic [7:0] PRESCALE_MAX = TICKS_PER_SEC - 8'd1;

`ifdef ELAPSED_HOURS_EN
  localparam int DW = 20;
`else
  localparam int DW = 16;
`endif

  elap_state_t   state_q, state_d;
  logic [7:0]    prescale_q, prescale_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [DW-1:0] live;
  logic          lap_active_q, lap_active_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          rollover_q, rollover_d;
  logic          sec_inc;
  logic          c_so, c_st, c_mo, c_mt;
  logic          wrap;
  logic [3:0]    so, st, mo, mt;

  // Live count cascade: each digit advances when the one below carries.
  bcd_digit #(.MAX_VAL(ONES_MAX)) u_sec_ones (.CLK(CLK), .RST_N(RST_N), .CLR(bus.CLR), .INC(sec_inc), .DIGIT(so), .CARRY(c_so));
  bcd_digit #(.MAX_VAL(TENS_MAX)) u_sec_tens (.CLK(CLK), .RST_N(RST_N), .CLR(bus.CLR), .INC(c_so),    .DIGIT(st), .CARRY(c_st));
  bcd_digit #(.MAX_VAL(ONES_MAX)) u_min_ones (.CLK(CLK), .RST_N(RST_N), .CLR(bus.CLR), .INC(c_st),    .DIGIT(mo), .CARRY(c_mo));
  bcd_digit #(.MAX_VAL(TENS_MAX)) u_min_tens (.CLK(CLK), .RST_N(RST_N), .CLR(bus.CLR), .INC(c_mo),    .DIGIT(mt), .CARRY(c_mt));

`ifdef ELAPSED_HOURS_EN
  logic [3:0] hr;
  logic       c_hr;
  bcd_digit #(.MAX_VAL(ONES_MAX)) u_hours (.CLK(CLK), .RST_N(RST_N), .CLR(bus.CLR), .INC(c_mt), .DIGIT(hr), .CARRY(c_hr));
  assign live = {hr, mt, mo, st, so};
  assign wrap = c_hr;
  assign bus.HOURS = disp_q[19:16];
`else
  assign live = {mt, mo, st, so};
  assign wrap = c_mt;
`endif

  // Next-state logic: each timer expiry re-arms while RUN stays high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ELAP_IDLE_S: if (bus.RUN) state_d = ELAP_WAIT_S;
      ELAP_WAIT_S: if (!bus.RUN) state_d = ELAP_IDLE_S;
      default:     state_d = ELAP_IDLE_S;
    endcase
    if (bus.CLR) state_d = ELAP_IDLE_S;
  end

  // Output / datapath logic. A pulse arriving with RUN low is still counted;
  // STOP_TMR is only needed when abandoning a timer interval still in flight.
  always_comb begin
    start_d    = 1'b0;
    stop_d     = 1'b0;
    sec_inc    = 1'b0;
    prescale_d = prescale_q;
    case (state_q)
      ELAP_IDLE_S: start_d = bus.RUN;
      ELAP_WAIT_S: begin
        if (bus.TMR_PULSE) begin
          start_d = bus.RUN;
          if (prescale_q == PRESCALE_MAX) begin
            prescale_d = 8'd0;
            sec_inc    = 1'b1;
          end else begin
            prescale_d = prescale_q + 8'd1;
          end
        end else begin
          stop_d = !bus.RUN;
        end
      end
      default: ;
    endcase
    rollover_d   = wrap;
    lap_active_d = lap_active_q ^ bus.LAP;
    // Freeze decision uses the post-LAP flag so un-freezing shows live at once.
    disp_d       = lap_active_d ? disp_q : live;
    if (bus.CLR) begin
      start_d      = 1'b0;
      stop_d       = 1'b0;
      sec_inc      = 1'b0;
      prescale_d   = 8'd0;
      rollover_d   = 1'b0;
      lap_active_d = 1'b0;
      disp_d       = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ELAP_IDLE_S;
      prescale_q   <= 8'd0;
      disp_q       <= '0;
      lap_active_q <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      rollover_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      disp_q       <= disp_d;
      lap_active_q <= lap_active_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      rollover_q   <= rollover_d;
    end
  end

  assign bus.START_TMR  = start_q;
  assign bus.STOP_TMR   = stop_q;
  assign bus.ROLLOVER   = rollover_q;
  assign bus.LAP_ACTIVE = lap_active_q;
  assign bus.SEC_ONES   = disp_q[3:0];
  assign bus.SEC_TENS   = disp_q[7:4];
  assign bus.MIN_ONES   = disp_q[11:8];
  assign bus.MIN_TENS   = disp_q[15:12];

endmodule

// File: tb/tb_elapsed_counter.sv
// ----------------------------------------------------------------------------
// tb_elapsed_counter
// Directed bench for elapsed_counter. Two instances share the same stimulus:
// busA/dutA with TICKS_PER_SEC=1 and busB/dutB with TICKS_PER_SEC=4.
// Define ELAPSED_HOURS_EN to also exercise the HOURS digit.
// ----------------------------------------------------------------------------
module tb_elapsed_counter;

  logic clk = 1'b0;
  logic rstN;
  int   checkCount = 0;
  int   errorCount = 0;
  int   rollCount  = 0;

  always #5 clk = ~clk;

  elapsed_counter_if busA ();
  elapsed_counter_if busB ();

  elapsed_counter #(.TICKS_PER_SEC(8'd1)) dutA (.CLK(clk), .RST_N(rstN), .bus(busA));
  elapsed_counter #(.TICKS_PER_SEC(8'd4)) dutB (.CLK(clk), .RST_N(rstN), .bus(busB));

  // Compare one observed value with its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the same controls into both instances.
  task automatic applyStimulus(input logic clr, input logic run, input logic lap, input logic pulse);
    busA.CLR = clr; busA.RUN = run; busA.LAP = lap; busA.TMR_PULSE = pulse;
    busB.CLR = clr; busB.RUN = run; busB.LAP = lap; busB.TMR_PULSE = pulse;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold TMR_PULSE high with RUN high for n cycles (one count per cycle).
  task automatic pulses(input int n);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (n) begin
      step();
      if (busA.ROLLOVER) rollCount++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] dispA();
    return {busA.MIN_TENS, busA.MIN_ONES, busA.SEC_TENS, busA.SEC_ONES};
  endfunction

  function automatic logic [15:0] dispB();
    return {busB.MIN_TENS, busB.MIN_ONES, busB.SEC_TENS, busB.SEC_ONES};
  endfunction

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_disp", dispA(), 16'h0000);
    checkOutput("reset_start", busA.START_TMR, 1'b0);
    checkOutput("reset_flags", {busA.STOP_TMR, busA.LAP_ACTIVE, busA.ROLLOVER}, 3'b000);
    @(negedge clk);
    rstN = 1'b1;

    // Idle until RUN rises, then START_TMR one cycle later only.
    repeat (8) step();
    checkOutput("idle_no_start", busA.START_TMR, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("run_start", busA.START_TMR, 1'b1);
    step();
    checkOutput("start_single", busA.START_TMR, 1'b0);

    // Three pulses, each re-armed one cycle later.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      checkOutput("rearm_start", busA.START_TMR, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("count_disp", dispA(), 16'(i));
    end

    // Pause with no pulse in flight: STOP_TMR once, count held.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("pause_stop", {busA.STOP_TMR, busA.START_TMR}, 2'b10);
    step();
    checkOutput("stop_single", busA.STOP_TMR, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("idle_ignores_pulse", dispA(), 16'h0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("resume_start", busA.START_TMR, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("resume_disp", dispA(), 16'h0004);

    // Pulse and RUN falling together: counted, no START/STOP, back to idle.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("fall_pulse_ss", {busA.START_TMR, busA.STOP_TMR}, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fall_pulse_nostop", busA.STOP_TMR, 1'b0);
    checkOutput("fall_pulse_disp", dispA(), 16'h0005);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("idle_after_fall", busA.START_TMR, 1'b1);

    // Clear, preload 59:58, then two pulses across the wrap.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("clr_disp", dispA(), 16'h0000);
    checkOutput("clr_no_start", busA.START_TMR, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("clr_then_start", busA.START_TMR, 1'b1);
    rollCount = 0;
    pulses(3598);
    step();
    checkOutput("preload_5958", dispA(), 16'h5958);
    checkOutput("preload_no_roll", rollCount, 0);
    pulses(2);
    step();
    checkOutput("roll_single_cycle", busA.ROLLOVER, 1'b0);
    checkOutput("roll_disp", dispA(), 16'h0000);
`ifdef ELAPSED_HOURS_EN
    checkOutput("roll_count", rollCount, 0);
    checkOutput("hours_carry", busA.HOURS, 4'd1);
`else
    checkOutput("roll_count", rollCount, 1);
`endif

    // Count to 12:34, then clear mid-count while frozen.
    pulses(754);
    step();
    checkOutput("disp_1234", dispA(), 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("lap_set", busA.LAP_ACTIVE, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("clr_mid_disp", dispA(), 16'h0000);
    checkOutput("clr_mid_flags", {busA.START_TMR, busA.LAP_ACTIVE}, 2'b00);
`ifdef ELAPSED_HOURS_EN
    checkOutput("clr_mid_hours", busA.HOURS, 4'd0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("clr_beats_lap", busA.LAP_ACTIVE, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("clr_idle_start", busA.START_TMR, 1'b1);
    pulses(1);
    step();
    checkOutput("clr_live_cleared", dispA(), 16'h0001);

    // TICKS_PER_SEC=4 instance: prescaling and lap freeze.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("b_start", busB.START_TMR, 1'b1);
    pulses(7);
    step();
    checkOutput("b_seven_pulses", dispB(), 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("b_lap_set", busB.LAP_ACTIVE, 1'b1);
    pulses(8);
    step();
    checkOutput("b_frozen", dispB(), 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("b_lap_clear", busB.LAP_ACTIVE, 1'b0);
    checkOutput("b_unfrozen", dispB(), 16'h0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

`ifdef ELAPSED_HOURS_EN
    // Full-range wrap at 9:59:59.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    rollCount = 0;
    pulses(35999);
    step();
    checkOutput("h_95959_disp", dispA(), 16'h5959);
    checkOutput("h_95959_hours", busA.HOURS, 4'd9);
    checkOutput("h_no_early_roll", rollCount, 0);
    pulses(1);
    checkOutput("h_roll", rollCount, 1);
    step();
    checkOutput("h_wrap_disp", {busA.HOURS, dispA()}, 20'h00000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/elapsed_counter.md
Name: elapsed_counter

Overview:
- Downstream consumer and re-arm controller for the one-shot `timer` block.
- Counts timer expiry pulses into a BCD mm:ss elapsed-time value and re-issues START_TMR after every expiry so the timer runs as a periodic tick source.
- Supports run/pause, clear, and a lap (display freeze) function.
- Outputs feed the 7-segment display mux.

Parameters:
- TICKS_PER_SEC, 8'd1: number of TMR_PULSE events per seconds increment. Legal range 1..255.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- CLR  input  1  synchronous clear. Same net drives the timer's CLR.
- RUN  input  1  level. 1 = count, 0 = pause.
- LAP  input  1  single-cycle pulse. Toggles display freeze.
- TMR_PULSE  input  1  timer PULSE output.
- START_TMR  output  1  single-cycle pulse to timer START_TMR.
- STOP_TMR  output  1  single-cycle pulse to timer STOP_TMR.
- SEC_ONES  output  4  displayed BCD seconds ones, 0-9.
- SEC_TENS  output  4  displayed BCD seconds tens, 0-5.
- MIN_ONES  output  4  displayed BCD minutes ones, 0-9.
- MIN_TENS  output  4  displayed BCD minutes tens, 0-5.
- LAP_ACTIVE  output  1  1 while the display is frozen.
- ROLLOVER  output  1  single-cycle pulse when the live count wraps.

Behaviour:
- All outputs are registered.
- Reset (RST_N=0, asynchronous) and CLR (synchronous, highest priority after reset) both do the following:
  - state=ELAP_IDLE_S.
  - Prescaler, live digits and displayed digits cleared to 0.
  - LAP_ACTIVE=0.
  - START_TMR=STOP_TMR=ROLLOVER=0.
- START_TMR, STOP_TMR and ROLLOVER default to 0 every cycle.
- ELAP_IDLE_S: if RUN=1, assert START_TMR the next cycle and go to ELAP_WAIT_S. Latency from RUN sampled high to START_TMR high is 1 cycle.
- ELAP_WAIT_S, TMR_PULSE=1:
  - Advance the prescaler. On reaching TICKS_PER_SEC-1 it wraps to 0 and the live count increments by one second.
  - If RUN=1: assert START_TMR next cycle and stay in ELAP_WAIT_S. The timer is back in its idle state by then.
  - If RUN=0: go to ELAP_IDLE_S with no STOP_TMR. The pulse is still counted.
- ELAP_WAIT_S, TMR_PULSE=0 and RUN=0: assert STOP_TMR for one cycle and go to ELAP_IDLE_S.
  - Live count and prescaler are held (pause). The partial timer interval is discarded.
- Live count cascade:
  - Seconds ones 9→0 carries into tens.
  - Seconds tens 5→0 carries into minutes.
  - Minutes follow the same 9/5 rule.
  - At 59:59 the next increment gives 00:00 and asserts ROLLOVER for one cycle. Counting continues.
- Display path:
  - LAP_ACTIVE=0: displayed digits track the live digits, one cycle behind them.
  - LAP pulse toggles LAP_ACTIVE. While LAP_ACTIVE=1 the displayed digits are held and the live count keeps running.
  - When LAP clears LAP_ACTIVE, the display shows the current live value on the next cycle.
- LAP is accepted in any state. LAP and CLR in the same cycle: CLR wins.
- Default/illegal state: go to ELAP_IDLE_S, no outputs pulsed.

Optional Feature:
- Macro ELAPSED_HOURS_EN.
- Defined:
  - Adds output HOURS (4 bits, BCD 0-9).
  - Minutes tens 5→0 carries into HOURS.
  - Rollover occurs at 9:59:59 → 0:00:00.
  - HOURS follows the same reset, CLR and lap-freeze rules as the other digits.
- Undefined:
  - HOURS port absent.
  - Rollover at 59:59.

Decomposition:
- Shared constants include (constants.vh): ELAP_IDLE_S and ELAP_WAIT_S state encodings, 2 bits, alongside the existing timer state constants.
- One sub-module, bcd_digit, instantiated once per digit:
  - Parameter MAX_VAL.
  - Inputs: CLK, RST_N, CLR, INC.
  - Outputs: DIGIT[3:0] and CARRY. CARRY is combinational, high when INC=1 and DIGIT=MAX_VAL.

Test Plan:
- Reset, then RUN=1 at cycle 10 → START_TMR high at cycle 11 only. Drive TMR_PULSE 3 times → display 00:03, START_TMR one cycle after each pulse.
- Preload 59:58 via 3598 pulses, then 2 more pulses → 00:00 and ROLLOVER pulses exactly once.
- RUN=0 while in ELAP_WAIT_S with no pulse → STOP_TMR for one cycle, count held. RUN=1 → START_TMR, counting resumes from the held value.
- TMR_PULSE and RUN falling in the same cycle → count +1, neither START_TMR nor STOP_TMR asserted, state ELAP_IDLE_S.
- TICKS_PER_SEC=4: 7 pulses → 00:01 displayed. LAP, 8 more pulses → display stays 00:01. LAP again → 00:03 next cycle.
- CLR asserted mid-count at 12:34 → all digits 0, no START_TMR. With ELAPSED_HOURS_EN: 35999 seconds (9:59:59) +1 → 0:00:00 and ROLLOVER.
